// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// Single-outstanding APB4 requester. Commands arrive on a valid/ready
// channel, are run through the APB SETUP and ACCESS phases, and complete
// on a valid/ready response channel. If the slave never raises pready,
// a programmable timeout counter aborts the access.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   cmd_*               command channel (valid/ready); write, addr, wdata,
//                       strb, prot
//   rsp_*               response channel (valid/ready); rdata, slverr,
//                       timeout
//   m_apb_*             APB4 requester port
//   dbg_state           current FSM state (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both 1. A producer holds valid and its payload
// stable until that edge. cmd_ready is 1 only in IDLE. rsp_valid and the
// rsp_* fields stay constant until rsp_ready is seen.
module apb_cmd_master #(
  parameter int REGWIDTH   = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [REGWIDTH-1:0]     cmd_wdata,
  input  logic [REGWIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [REGWIDTH-1:0]     rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [REGWIDTH-1:0]     m_apb_pwdata,
  output logic [REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                    m_apb_pready,
  input  logic [REGWIDTH-1:0]     m_apb_prdata,
  input  logic                    m_apb_pslverr,
  output logic [1:0]              dbg_state
);

  localparam int STRB_W = REGWIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT != 0);
  // Counter value during the last ACCESS cycle allowed before the abort.
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [REGWIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [REGWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pprot_d       = pprot_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q is 0 right after reset release, so this also
        // blocks acceptance until the block is really ready.
        if (cmd_valid && cmd_ready_q) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pprot_d   = cmd_prot;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb  : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (m_apb_pready) begin
          // pready takes priority over a timeout on the same edge.
          rsp_rdata_d   = pwrite_q ? '0 : m_apb_prdata;
          rsp_slverr_d  = m_apb_pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cnt_d         = cnt_q + CNT_W'(1);
          state_d       = RESP;
        end else if (cnt_q != CNT_MAX) begin
          // Saturates, so a disabled timeout never wraps back to zero.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered, so cmd_ready follows the state with no combinational path.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pprot_q       <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pprot_q       <= pprot_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_slverr    = rsp_slverr_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_pprot   = pprot_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pstrb   = pstrb_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
// Directed bench for apb_cmd_master. "dut" (TIMEOUT=16) talks to a small
// APB memory slave whose wait states, error and hang can be controlled.
// "dut0" (TIMEOUT=0) has a hand-driven pready and is used only to show
// that an access with the timeout disabled waits with no limit.
module tb_apb_cmd_master;
  localparam int RW = 32;
  localparam int AW = 7;
  localparam int SW = RW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          cmd_valid = 1'b0, cmd_valid0 = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [RW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb  = '0;
  logic [2:0]    cmd_prot  = '0;
  logic          rsp_ready = 1'b1;

  logic          cmd_ready, rsp_valid, rsp_slverr, rsp_timeout;
  logic [RW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [2:0]    pprot;
  logic [AW-1:0] paddr;
  logic [RW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;
  logic [1:0]    dbg_state;

  logic          cmd_ready0, rsp_valid0, rsp_slverr0, rsp_timeout0;
  logic [RW-1:0] rsp_rdata0;
  logic          psel0, penable0, pwrite0;
  logic          pready0 = 1'b0;
  logic [RW-1:0] prdata0 = 32'h1234_5678;
  logic          pslverr0 = 1'b0;
  logic [2:0]    pprot0;
  logic [AW-1:0] paddr0;
  logic [RW-1:0] pwdata0;
  logic [SW-1:0] pstrb0;
  logic [1:0]    dbg_state0;

  apb_cmd_master #(.REGWIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite),
    .m_apb_pprot(pprot), .m_apb_paddr(paddr), .m_apb_pwdata(pwdata),
    .m_apb_pstrb(pstrb), .m_apb_pready(pready), .m_apb_prdata(prdata),
    .m_apb_pslverr(pslverr), .dbg_state(dbg_state)
  );

  apb_cmd_master #(.REGWIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
    .rsp_slverr(rsp_slverr0), .rsp_timeout(rsp_timeout0),
    .m_apb_psel(psel0), .m_apb_penable(penable0), .m_apb_pwrite(pwrite0),
    .m_apb_pprot(pprot0), .m_apb_paddr(paddr0), .m_apb_pwdata(pwdata0),
    .m_apb_pstrb(pstrb0), .m_apb_pready(pready0), .m_apb_prdata(prdata0),
    .m_apb_pslverr(pslverr0), .dbg_state(dbg_state0)
  );

  // ---------------- APB memory slave ----------------
  int          slave_waits = 0;
  bit          slave_hang  = 1'b0;
  bit          slave_err   = 1'b0;
  int          acc_cnt     = 0;
  logic [31:0] mem [32];

  assign pready  = !slave_hang && (acc_cnt >= slave_waits);
  assign prdata  = mem[paddr[6:2]];
  assign pslverr = slave_err;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else if (!(psel && penable))    acc_cnt <= 0;
    if (psel && penable && pready && pwrite)
      for (int b = 0; b < SW; b++)
        if (pstrb[b]) mem[paddr[6:2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int            r_lat, r_acc;
  bit            r_stable;
  logic [RW-1:0] r_rdata;
  logic          r_slverr, r_timeout, r_psel;

  // Issue one command and follow it to its response. r_lat counts cycles
  // from the acceptance edge (cycle 0) to the cycle rsp_valid is seen.
  task automatic do_cmd(input bit wr, input logic [AW-1:0] a,
                        input logic [RW-1:0] d, input logic [SW-1:0] s,
                        input bit both);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_write  = wr;
    cmd_addr   = a;
    cmd_wdata  = d;
    cmd_strb   = s;
    cmd_valid  = 1'b1;
    cmd_valid0 = both;
    tick();
    cmd_valid  = 1'b0;
    cmd_valid0 = 1'b0;
    r_lat    = 1;
    r_acc    = 0;
    r_stable = 1'b1;
    while (!rsp_valid && r_lat < 64) begin
      if (psel && penable) begin
        r_acc++;
        if (paddr !== a || pwrite !== wr || pwdata !== (wr ? d : '0) ||
            pstrb !== (wr ? s : '0))
          r_stable = 1'b0;
      end
      tick();
      r_lat++;
    end
    check("rsp_arrived", rsp_valid, 1);
    check("apb_stable", r_stable, 1);
    r_rdata   = rsp_rdata;
    r_slverr  = rsp_slverr;
    r_timeout = rsp_timeout;
    r_psel    = psel;
    if (rsp_ready) tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    #1 rst = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write 0xDEADBEEF to 0x08, zero wait states, cycle by cycle.
    cmd_write = 1'b1; cmd_addr = 7'h08; cmd_wdata = 32'hDEAD_BEEF;
    cmd_strb = 4'hF; cmd_prot = 3'b101; cmd_valid = 1'b1;
    tick();                                     // acceptance edge
    cmd_valid = 1'b0;
    check("w_c1_psel", psel, 1);
    check("w_c1_penable", penable, 0);
    check("w_c1_paddr", paddr, 7'h08);
    check("w_c1_pprot", pprot, 3'b101);
    check("w_c1_cmd_ready", cmd_ready, 0);
    tick();
    check("w_c2_psel", psel, 1);
    check("w_c2_penable", penable, 1);
    check("w_c2_pwdata", pwdata, 32'hDEAD_BEEF);
    check("w_c2_pstrb", pstrb, 4'hF);
    check("w_c2_rsp_valid", rsp_valid, 0);
    tick();
    check("w_c3_psel", psel, 0);
    check("w_c3_penable", penable, 0);
    check("w_c3_rsp_valid", rsp_valid, 1);
    check("w_c3_slverr", rsp_slverr, 0);
    check("w_c3_rdata", rsp_rdata, 0);
    tick();
    check("w_c4_rsp_valid", rsp_valid, 0);
    check("w_c4_cmd_ready", cmd_ready, 1);
    cmd_prot = 3'b000;

    // Read back 0x08; apb_stable covers pwdata/pstrb == 0 during the read.
    exp_q.push_back(32'hDEAD_BEEF);
    do_cmd(1'b0, 7'h08, 32'hFFFF_FFFF, 4'hF, 1'b0);
    check("rd08_lat", r_lat, 3);
    check("rd08_rdata", r_rdata, exp_q.pop_front());

    // Partial strobes then a read with 3 wait states.
    do_cmd(1'b1, 7'h10, 32'hFFFF_FFFF, 4'hF, 1'b0);
    do_cmd(1'b1, 7'h10, 32'h1122_3344, 4'h5, 1'b0);
    slave_waits = 3;
    exp_q.push_back(32'hFF22_FF44);
    do_cmd(1'b0, 7'h10, '0, '0, 1'b0);
    check("ws3_lat", r_lat, 6);
    check("ws3_access_cycles", r_acc, 4);
    check("ws3_rdata", r_rdata, exp_q.pop_front());
    slave_waits = 0;

    // Slave error on a write.
    slave_err = 1'b1;
    do_cmd(1'b1, 7'h0C, 32'h0BAD_0BAD, 4'hF, 1'b0);
    slave_err = 1'b0;
    check("err_lat", r_lat, 3);
    check("err_slverr", r_slverr, 1);
    check("err_timeout", r_timeout, 0);
    check("err_rdata", r_rdata, 0);

    // Hung slave: dut aborts after 16 ACCESS cycles, dut0 keeps waiting.
    slave_hang = 1'b1;
    do_cmd(1'b0, 7'h08, '0, '0, 1'b1);
    check("to_lat", r_lat, 18);
    check("to_access_cycles", r_acc, 16);
    check("to_psel", r_psel, 0);
    check("to_slverr", r_slverr, 1);
    check("to_timeout", r_timeout, 1);
    check("to_rdata", r_rdata, 0);
    slave_hang = 1'b0;
    repeat (20) tick();
    check("to0_psel", psel0, 1);
    check("to0_penable", penable0, 1);
    check("to0_rsp_valid", rsp_valid0, 0);
    check("to0_state", dbg_state0, 2);
    pready0 = 1'b1;
    tick();
    pready0 = 1'b0;
    check("to0_rsp_valid_late", rsp_valid0, 1);
    check("to0_rdata", rsp_rdata0, 32'h1234_5678);
    check("to0_timeout", rsp_timeout0, 0);
    check("to0_slverr", rsp_slverr0, 0);
    tick();
    check("to0_rsp_done", rsp_valid0, 0);

    // Response backpressure with a command waiting.
    rsp_ready = 1'b0;
    exp_q.push_back(32'hFF22_FF44);
    do_cmd(1'b0, 7'h10, '0, '0, 1'b0);
    check("bp_lat", r_lat, 3);
    check("bp_rdata", r_rdata, exp_q.pop_front());
    cmd_write = 1'b1; cmd_addr = 7'h14; cmd_wdata = 32'hCAFE_F00D;
    cmd_strb = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_rdata", rsp_rdata, 32'hFF22_FF44);
      check("bp_hold_cmd_ready", cmd_ready, 0);
      check("bp_hold_psel", psel, 0);
    end
    rsp_ready = 1'b1;
    tick();                                     // handshake edge
    check("bp_hs_rsp_valid", rsp_valid, 0);
    check("bp_hs_psel", psel, 0);
    check("bp_hs_cmd_ready", cmd_ready, 1);
    tick();                                     // acceptance edge
    cmd_valid = 1'b0;
    check("bp_acc_psel", psel, 1);
    check("bp_acc_paddr", paddr, 7'h14);
    check("bp_acc_pwrite", pwrite, 1);
    check("bp_acc_pwdata", pwdata, 32'hCAFE_F00D);
    tick();
    tick();
    check("bp_w_rsp_valid", rsp_valid, 1);
    check("bp_w_slverr", rsp_slverr, 0);
    tick();
    exp_q.push_back(32'hCAFE_F00D);
    do_cmd(1'b0, 7'h14, '0, '0, 1'b0);
    check("bp_rd14_rdata", r_rdata, exp_q.pop_front());

    // Reset during ACCESS of a read.
    slave_waits = 10;
    cmd_write = 1'b0; cmd_addr = 7'h08; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mr_state_access", dbg_state, 2);
    check("mr_psel_before", psel, 1);
    #2 rst = 1'b0;
    #1;
    check("mr_psel", psel, 0);
    check("mr_penable", penable, 0);
    check("mr_paddr", paddr, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_cmd_ready", cmd_ready, 0);
    check("mr_state", dbg_state, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    slave_waits = 0;
    tick();
    check("mr_post_cmd_ready", cmd_ready, 1);
    check("mr_post_rsp_valid", rsp_valid, 0);
    do_cmd(1'b1, 7'h18, 32'h55AA_55AA, 4'hF, 1'b0);
    check("mr_w_lat", r_lat, 3);
    check("mr_w_slverr", r_slverr, 0);
    exp_q.push_back(32'h55AA_55AA);
    do_cmd(1'b0, 7'h18, '0, '0, 1'b0);
    check("mr_rd_rdata", r_rdata, exp_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-outstanding APB4 requester that drives the `s_apb_*` slave port of the register-bank DUT.
- Upstream logic or a testbench issues commands over a valid/ready interface. The block runs APB SETUP/ACCESS phases, waits on `pready`, and returns read data and error status on a valid/ready response channel.
- A programmable timeout counter aborts accesses whose slave never asserts `pready`.

Parameters:
- REGWIDTH, 32, data width in bits; multiple of 8.
- ADDR_WIDTH, 7, APB address width; matches $clog2(32 regs)+$clog2(32/8).
- TIMEOUT, 16, maximum ACCESS cycles without `pready` before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  REGWIDTH  write data.
- cmd_strb  in  REGWIDTH/8  byte strobes.
- cmd_prot  in  3  APB protection bits.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  REGWIDTH  read data; 0 for writes and for timeouts.
- rsp_slverr  out  1  slave error or timeout.
- rsp_timeout  out  1  access aborted by timeout.
- m_apb_psel, m_apb_penable, m_apb_pwrite  out  1 each  APB control.
- m_apb_pprot  out  3  APB protection.
- m_apb_paddr  out  ADDR_WIDTH  APB address.
- m_apb_pwdata  out  REGWIDTH  APB write data.
- m_apb_pstrb  out  REGWIDTH/8  APB strobes.
- m_apb_pready  in  1  slave ready.
- m_apb_prdata  in  REGWIDTH  slave read data.
- m_apb_pslverr  in  1  slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and response fields are registered.
- Reset (`rst`=0), asynchronous:
  - state = IDLE.
  - `psel`, `penable`, `pwrite`, `pprot`, `paddr`, `pwdata`, `pstrb` = 0.
  - `rsp_valid`, `rsp_rdata`, `rsp_slverr`, `rsp_timeout` = 0.
  - timeout counter = 0.
  - `cmd_ready` = 0 while `rst` is asserted, 1 in the first cycle after release.
- IDLE:
  - `cmd_ready`=1. A command is accepted when `cmd_valid` & `cmd_ready` on a rising edge.
  - On acceptance, latch `addr`, `write`, `prot`. Latch `wdata` and `strb` for writes; for reads, force `pwdata`=0 and `pstrb`=0.
  - Next state SETUP; `psel`=1, `penable`=0.
- SETUP: lasts exactly 1 cycle. Next state ACCESS; `penable`=1. The timeout counter clears entering ACCESS.
- ACCESS: `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot` are held stable until the phase ends.
  - `pready`=1 on an edge:
    - Capture `rsp_rdata` = `prdata` for reads, 0 for writes.
    - Capture `rsp_slverr` = `pslverr`; `rsp_timeout`=0.
    - `psel`, `penable` → 0; `rsp_valid` → 1; next state RESP.
  - `pready`=0: counter increments.
  - Counter reaches TIMEOUT (TIMEOUT≠0) with `pready` still 0:
    - Abort on that edge: `psel`, `penable` → 0.
    - `rsp_slverr`=1, `rsp_timeout`=1, `rsp_rdata`=0; next state RESP.
  - `pready` and the timeout on the same edge: `pready` wins and the response is normal.
- RESP:
  - `rsp_valid` and the response fields are held stable until `rsp_ready`=1 on an edge.
  - Then `rsp_valid` → 0 and next state IDLE.
  - `cmd_ready`=0 throughout RESP; no command is accepted in the handshake cycle.
- Latency, with acceptance edge at cycle 0:
  - SETUP in cycle 1, ACCESS from cycle 2.
  - Zero-wait-state response: `rsp_valid`=1 in cycle 3.
  - Each wait state adds 1 cycle.
  - Minimum command-to-command spacing is 4 cycles with `rsp_ready` tied high.
- `cmd_*` inputs are ignored outside IDLE.
- Reset mid-transaction: immediate return to IDLE, APB outputs and any pending response are dropped, and no response is produced.
- Counter width is $clog2(TIMEOUT+1) bits, minimum 1. It saturates and never wraps.

Test Plan:
- Write 0xDEADBEEF to addr 0x08 with strb 0xF, slave `pready` tied 1:
  - `psel` high 2 cycles, `penable` high 1 cycle.
  - `pwdata`=0xDEADBEEF; `rsp_valid` in cycle 3 with `rsp_slverr`=0.
  - Read back from 0x08 → `rsp_rdata`=0xDEADBEEF, and `pstrb`=0 during the read.
- Read with the slave inserting 3 wait states:
  - `paddr` and `pwrite` stable across all 4 ACCESS cycles.
  - `rsp_valid` in cycle 6 with the captured `prdata`.
- Slave returns `pslverr`=1 with `pready` on a write:
  - `rsp_slverr`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- `pready` held 0 with TIMEOUT=16:
  - Abort after 16 ACCESS cycles: `psel` drops.
  - `rsp_slverr`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - A second run with TIMEOUT=0 waits indefinitely.
- Response backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - Response fields stay stable and `cmd_ready` stays 0.
  - A command asserted during this window is accepted only after the handshake.
- Assert `rst` low during ACCESS of a read:
  - All outputs 0 asynchronously, no `rsp_valid`.
  - After release `cmd_ready`=1, and a new write completes normally.
